axi_frame_writer: RTL and testbench
===================================

AXI_FRAME_WRITER -- requirements
Module: axi_frame_writer

Interface
REQ-001 Parameter BASE_ADDR, default 28'h0000000, DDR byte-agnostic word address (32-bit units) of frame buffer 0.
REQ-002 Parameter FRAME_STRIDE, default 28'h0100000, address offset between frame buffer 0 and frame buffer 1.
REQ-003 Parameter FIFO_DEPTH, default 32, internal 256-bit word buffer depth; power of two, >= 32.
REQ-004 clk  input  1  DDR PHY clock; all logic on rising edge.
REQ-005 rst  input  1  one clock; reset is synchronous and active-high.
REQ-006 pix_valid  input  1  RGB565 pixel strobe, already in clk domain.
REQ-007 pix_data  input  16  RGB565 pixel.
REQ-008 frame_end  input  1  single-cycle pulse after the last pixel of a frame.
REQ-009 axi_awaddr  output  28; axi_awlen  output  4; axi_awuser_id  output  4; axi_awuser_ap  output  1; axi_awvalid  output  1; axi_awready  input  1.
REQ-010 axi_wdata  output  256; axi_wstrb  output  32; axi_wready  input  1.
REQ-011 frame_sel  output  1  buffer currently being written; overflow  output  1  sticky drop flag; busy  output  1  high when not IDLE or FIFO non-empty.

Function
REQ-012 Packer: 16 consecutive pixels form one 256-bit word, pixel 0 at bits [15:0], pixel 15 at [255:240]; full word pushed to FIFO the cycle after the 16th pix_valid.
REQ-013 pix_valid while FIFO full (and packer full): pixel dropped, overflow set, held until rst.
REQ-014 States IDLE, ADDR, DATA, PAD. IDLE->ADDR when FIFO count >= 16 or pending flush. ADDR: awvalid=1, awaddr/awlen stable until awready; on handshake -> DATA.
REQ-015 axi_awlen fixed 4'd15 (16 beats); axi_awuser_id 4'd0; axi_awuser_ap 1'b0; axi_wstrb all ones.
REQ-016 DATA: axi_wdata presents FIFO head combinationally; each cycle with axi_wready consumes one word; after 16th consumed beat -> IDLE. No wvalid exists; FIFO must hold 16 words before ADDR (REQ-014) so wready never underflows, except in flush.
REQ-017 Address: burst n of a frame at BASE_ADDR + frame_sel*FRAME_STRIDE + n*128 (8 per beat); 28-bit wrap-around permitted, not checked.
REQ-018 frame_end: partial packer word zero-padded and pushed; flush pending set; remaining words of the final burst supplied as zero words (PAD behaves as DATA with wdata=0 once FIFO empty).
REQ-019 After final flushed burst completes: burst counter cleared, frame_sel toggles, flush pending cleared.
REQ-020 frame_end with packer and FIFO empty and burst counter 0: no burst, frame_sel does not toggle.
REQ-021 pix_valid and frame_end same cycle: pixel included in ending frame.
REQ-022 Pixels after frame_end are accepted into the next frame while flush drains; they never enter PAD words.
REQ-023 Throughput: sustained 1 pixel/clk accepted without drop when awready latency <= 8 clk and wready continuous.

Reset
REQ-024 rst high for one clk: state IDLE, FIFO and packer empty, burst counter 0, frame_sel 0, overflow 0, axi_awvalid 0, busy 0, axi_awaddr BASE_ADDR.
REQ-025 rst mid-burst: transaction abandoned immediately, no further beats; controller-side recovery is system responsibility.

Verification
REQ-026 256 pixels values 0..255, awready/wready always 1 -> one burst at BASE_ADDR, beat k wdata lane j = 16k+j.
REQ-027 512 pixels then frame_end, repeat -> bursts at BASE_ADDR, +128, then BASE_ADDR+FRAME_STRIDE, +128; frame_sel 0->1->0.
REQ-028 20 pixels then frame_end -> one burst: beat 0 full, beat 1 lanes 0..3 data, rest 0, beats 2..15 zero; frame_sel toggles.
REQ-029 awready held 0, continuous pixels -> overflow set after FIFO_DEPTH*16+16 pixels; releasing awready drains exactly FIFO_DEPTH words, no gap.
REQ-030 wready toggling 1/0 randomly -> exactly 16 words consumed per burst, data order preserved.
REQ-031 rst asserted in DATA at beat 7 -> next clk awvalid 0, busy 0, frame_sel 0, subsequent 256 pixels burst at BASE_ADDR.

Source files
------------

// File: rtl/axi_frame_writer.sv
// axi_frame_writer: packs RGB565 pixels into 256-bit words, writes 16-beat AXI bursts.
// Ports: clk/rst; pix_valid/pix_data/frame_end in; AXI AW/W out; frame_sel/overflow/busy.
module axi_frame_writer #(
  parameter logic [27:0] BASE_ADDR    = 28'h0000000,
  parameter logic [27:0] FRAME_STRIDE = 28'h0100000,
  parameter int          FIFO_DEPTH   = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pix_valid,
  input  logic [15:0]  pix_data,
  input  logic         frame_end,
  output logic [27:0]  axi_awaddr,
  output logic [3:0]   axi_awlen,
  output logic [3:0]   axi_awuser_id,
  output logic         axi_awuser_ap,
  output logic         axi_awvalid,
  input  logic         axi_awready,
  output logic [255:0] axi_wdata,
  output logic [31:0]  axi_wstrb,
  input  logic         axi_wready,
  output logic         frame_sel,
  output logic         overflow,
  output logic         busy
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, PAD} state_t;

  state_t state, state_nx;

  logic [255:0]  mem [FIFO_DEPTH];
  logic [AW:0]   wp, rp, fcnt, fcnt_nx;
  logic          ffull, push, pop;

  logic [255:0]  pk_data, pk_data_nx;
  logic [3:0]    pk_cnt;
  logic          pk_full, pk_full_nx;
  logic [4:0]    fill;
  logic          room, take, drop;

  logic          flush;
  logic [AW+1:0] fl_left, fl_set, fl_after;
  logic [3:0]    beat;
  logic [20:0]   burst_cnt;
  logic          sel, ovf;
  logic          beat_en, last_beat, fin;

  assign fcnt  = wp - rp;
  assign ffull = fcnt[AW];

  // A full packer word waits here until the FIFO has room;
  // a new pixel may enter the same cycle that word leaves.
  assign push = pk_full && !ffull;
  assign room = !pk_full || push;
  assign take = pix_valid && room;
  assign drop = pix_valid && !room;
  assign fill = {1'b0, pk_cnt} + {4'd0, take};

  assign pk_full_nx = fill[4]
                   || (frame_end && fill != 5'd0)
                   || (pk_full && !push);

  always_comb begin
    pk_data_nx = push ? '0 : pk_data;
    if (take) pk_data_nx[{pk_cnt, 4'b0} +: 16] = pix_data;
  end

  assign pop     = axi_wready && (state == DATA);
  assign beat_en = axi_wready && (state == DATA || state == PAD);
  assign fcnt_nx = fcnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  // Words still owed to the ending frame: FIFO after this
  // cycle plus a packer word about to be pushed. Words queued
  // later belong to the next frame and never fill PAD beats.
  assign fl_set   = {1'b0, fcnt_nx} + {{(AW+1){1'b0}}, pk_full_nx};
  assign fl_after = fl_left - {{(AW+1){1'b0}}, flush && pop};

  always_comb begin
    state_nx  = state;
    last_beat = 1'b0;
    fin       = 1'b0;
    unique case (state)
      IDLE: begin
        if (flush && fl_left == '0) fin = 1'b1;
        else if (fcnt >= (AW+1)'(16) || flush) state_nx = ADDR;
      end
      ADDR: begin
        if (axi_awready) state_nx = (flush && fl_left == '0) ? PAD : DATA;
      end
      DATA, PAD: begin
        if (beat_en) begin
          if (beat == 4'd15) begin
            last_beat = 1'b1;
            state_nx  = IDLE;
            fin       = flush && fl_after == '0;
          end else if (flush && fl_after == '0) begin
            state_nx = PAD;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp[AW-1:0]] <= pk_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wp        <= '0;
      rp        <= '0;
      pk_data   <= '0;
      pk_cnt    <= '0;
      pk_full   <= 1'b0;
      flush     <= 1'b0;
      fl_left   <= '0;
      beat      <= '0;
      burst_cnt <= '0;
      sel       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      state   <= state_nx;
      pk_data <= pk_data_nx;
      pk_full <= pk_full_nx;
      pk_cnt  <= pk_full_nx ? 4'd0 : fill[3:0];
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      if (drop) ovf <= 1'b1;
      if (beat_en) beat <= beat + 1'b1;
      if (fin) begin
        burst_cnt <= '0;
        sel       <= ~sel;
      end else if (last_beat) begin
        burst_cnt <= burst_cnt + 1'b1;
      end
      fl_left <= frame_end ? fl_set : fl_after;
      if (frame_end && (fl_set != '0 || burst_cnt != '0 || state != IDLE))
        flush <= 1'b1;
      else if (fin)
        flush <= 1'b0;
    end
  end

  assign axi_awaddr    = BASE_ADDR
                       + (sel ? FRAME_STRIDE : 28'd0)
                       + {burst_cnt, 7'd0};
  assign axi_awlen     = 4'd15;
  assign axi_awuser_id = 4'd0;
  assign axi_awuser_ap = 1'b0;
  assign axi_awvalid   = (state == ADDR);
  assign axi_wdata     = (state == PAD) ? '0 : mem[rp[AW-1:0]];
  assign axi_wstrb     = '1;
  assign frame_sel     = sel;
  assign overflow      = ovf;
  assign busy          = (state != IDLE) || (fcnt != '0);
endmodule

// File: tb/tb_axi_frame_writer.sv
// tb_axi_frame_writer: random and directed pixel streams against a frame-level model.
// Ports: none; drives axi_frame_writer and checks captured bursts and status.
module tb_axi_frame_writer;
  localparam logic [27:0] BASE   = 28'h0123400;
  localparam logic [27:0] STRIDE = 28'h0100000;
  localparam int          DEPTH  = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         pix_valid = 1'b0;
  logic [15:0]  pix_data = '0;
  logic         frame_end = 1'b0;
  logic         axi_awready = 1'b0;
  logic         axi_wready = 1'b0;
  logic [27:0]  axi_awaddr;
  logic [3:0]   axi_awlen;
  logic [3:0]   axi_awuser_id;
  logic         axi_awuser_ap;
  logic         axi_awvalid;
  logic [255:0] axi_wdata;
  logic [31:0]  axi_wstrb;
  logic         frame_sel;
  logic         overflow;
  logic         busy;

  axi_frame_writer #(
    .BASE_ADDR(BASE),
    .FRAME_STRIDE(STRIDE),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pix_valid(pix_valid),
    .pix_data(pix_data),
    .frame_end(frame_end),
    .axi_awaddr(axi_awaddr),
    .axi_awlen(axi_awlen),
    .axi_awuser_id(axi_awuser_id),
    .axi_awuser_ap(axi_awuser_ap),
    .axi_awvalid(axi_awvalid),
    .axi_awready(axi_awready),
    .axi_wdata(axi_wdata),
    .axi_wstrb(axi_wstrb),
    .axi_wready(axi_wready),
    .frame_sel(frame_sel),
    .overflow(overflow),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [255:0] got,
                     input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [27:0]  cap_addr[$];
  logic [255:0] cap_word[$];
  logic [255:0] tmp[$];
  logic [27:0]  pend;
  bit           bursting = 0;

  always @(negedge clk) begin
    if (rst) begin
      bursting = 0;
      tmp.delete();
    end else begin
      if (bursting && axi_wready) begin
        tmp.push_back(axi_wdata);
        if (tmp.size() == 16) begin
          cap_addr.push_back(pend);
          foreach (tmp[i]) cap_word.push_back(tmp[i]);
          tmp.delete();
          bursting = 0;
        end
      end
      if (axi_awvalid && axi_awready) begin
        pend = axi_awaddr;
        bursting = 1;
      end
    end
  end

  logic [27:0]  exp_addr[$];
  logic [255:0] exp_word[$];
  logic [15:0]  fpix[$];
  bit           m_sel = 0;
  bit           rand_rdy = 0;

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_rdy) begin
      axi_awready = ($urandom % 3) == 0;
      axi_wready  = ($urandom % 2) == 1;
    end
  end

  // Frame of N pixels -> ceil(N/16) zero-padded words, rounded up to
  // whole 16-word bursts; unframed data only yields complete bursts.
  task automatic model_close(input bit framed);
    int nw;
    int nb;
    logic [255:0] w;
    nw = (fpix.size() + 15) / 16;
    nb = framed ? (nw + 15) / 16 : fpix.size() / 256;
    for (int b = 0; b < nb; b++) begin
      exp_addr.push_back(BASE + (m_sel ? STRIDE : 28'd0) + 28'(b * 128));
      for (int k = 0; k < 16; k++) begin
        w = '0;
        for (int j = 0; j < 16; j++) begin
          int idx;
          idx = (b * 16 + k) * 16 + j;
          if (idx < fpix.size()) w[j*16 +: 16] = fpix[idx];
        end
        exp_word.push_back(w);
      end
    end
    if (framed && nb > 0) m_sel = !m_sel;
    fpix.delete();
  endtask

  task automatic send_frame(input int n, input int gap_pct, input bit seq,
                            input bit do_end, input bit end_same);
    for (int i = 0; i < n; i++) begin
      while (gap_pct != 0 && $urandom_range(99, 0) < gap_pct) begin
        pix_valid = 0;
        @(posedge clk);
        #1;
      end
      pix_valid = 1;
      pix_data  = seq ? 16'(i) : 16'($urandom);
      fpix.push_back(pix_data);
      frame_end = do_end && end_same && (i == n - 1);
      @(posedge clk);
      #1;
    end
    pix_valid = 0;
    if (do_end && !(end_same && n > 0)) begin
      frame_end = 1;
      @(posedge clk);
      #1;
    end
    frame_end = 0;
    if (do_end) model_close(1);
  endtask

  task automatic drain(input string tag, input int limit);
    int quiet;
    int n;
    quiet = 0;
    n = 0;
    while (quiet < 40 && n < limit) begin
      @(negedge clk);
      n++;
      quiet = (busy || axi_awvalid) ? 0 : quiet + 1;
    end
    chk({tag, "_drain"}, quiet >= 40, 1);
  endtask

  task automatic compare(input string tag);
    chk({tag, "_nburst"}, cap_addr.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < cap_addr.size(); i++)
      chk({tag, "_addr"}, cap_addr[i], exp_addr[i]);
    for (int i = 0; i < exp_word.size() && i < cap_word.size(); i++)
      chk({tag, "_word"}, cap_word[i], exp_word[i]);
    cap_addr.delete();
    cap_word.delete();
    exp_addr.delete();
    exp_word.delete();
  endtask

  task automatic do_reset();
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    m_sel = 0;
    fpix.delete();
    cap_addr.delete();
    cap_word.delete();
    exp_addr.delete();
    exp_word.delete();
  endtask

  initial begin
    int n;
    bit es;
    bit seen7;
    do_reset();
    @(negedge clk);
    chk("rst_awvalid", axi_awvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sel", frame_sel, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_awaddr", axi_awaddr, BASE);
    chk("awlen", axi_awlen, 15);
    chk("awuser", {axi_awuser_id, axi_awuser_ap}, 0);
    chk("wstrb", axi_wstrb, 32'hffff_ffff);

    // 256 sequential pixels, one burst
    @(posedge clk);
    #1;
    axi_awready = 1;
    axi_wready  = 1;
    send_frame(256, 0, 1, 0, 0);
    model_close(0);
    drain("seq", 2000);
    compare("seq");
    do_reset();

    // two frames of 512 pixels at full rate
    axi_awready = 1;
    axi_wready  = 1;
    send_frame(512, 0, 0, 1, 0);
    drain("f0", 2000);
    chk("f0_sel", frame_sel, m_sel);
    send_frame(512, 0, 0, 1, 0);
    drain("f1", 2000);
    chk("f1_sel", frame_sel, m_sel);
    chk("f1_no_ovf", overflow, 0);
    compare("two_frames");

    // short frame padded into one burst
    send_frame(20, 0, 0, 1, 0);
    drain("short", 2000);
    chk("short_sel", frame_sel, m_sel);
    compare("short");

    // random frames, random handshakes, back-to-back
    rand_rdy = 1;
    for (int f = 0; f < 5; f++) begin
      n  = $urandom_range(800, 300);
      es = ($urandom % 2) == 1;
      send_frame(n, 25, 0, 1, es);
    end
    drain("rand", 20000);
    rand_rdy = 0;
    @(posedge clk);
    #1;
    axi_awready = 1;
    axi_wready  = 1;
    chk("rand_sel", frame_sel, m_sel);
    chk("rand_no_ovf", overflow, 0);
    compare("rand");

    // frame_end with nothing buffered
    send_frame(0, 0, 0, 1, 0);
    drain("empty", 2000);
    chk("empty_sel", frame_sel, m_sel);
    compare("empty");

    // overflow with awready held low
    do_reset();
    axi_awready = 0;
    axi_wready  = 1;
    send_frame(DEPTH * 16 + 16, 0, 1, 0, 0);
    @(negedge clk);
    chk("ovf_before", overflow, 0);
    @(posedge clk);
    #1;
    pix_valid = 1;
    pix_data  = 16'hdead;
    @(posedge clk);
    #1;
    pix_valid = 0;
    @(negedge clk);
    chk("ovf_after", overflow, 1);
    axi_awready = 1;
    model_close(0);
    repeat (200) @(posedge clk);
    #1;
    chk("ovf_sticky", overflow, 1);
    compare("ovf_drain");

    // reset in the middle of a burst
    do_reset();
    axi_awready = 1;
    axi_wready  = 1;
    send_frame(256, 0, 1, 0, 0);
    fpix.delete();
    seen7 = 0;
    for (int c = 0; c < 300 && !seen7; c++) begin
      @(posedge clk);
      if (tmp.size() == 7) seen7 = 1;
    end
    chk("beat7_seen", seen7, 1);
    #1;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("mid_awvalid", axi_awvalid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_sel", frame_sel, 0);
    cap_addr.delete();
    cap_word.delete();
    m_sel = 0;
    @(posedge clk);
    #1;
    send_frame(256, 0, 0, 0, 0);
    model_close(0);
    drain("after_rst", 2000);
    compare("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
